// File: rtl/fb_bank_controller_pkg.sv
// Shared display definitions: bank-controller state encoding and address-width derivation.
package fb_bank_controller_pkg;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_PENDING = 2'd2,
    ST_SWAP    = 2'd3
  } fb_state_e;

  function automatic int rb_f(input int n_rows);
    return (n_rows > 1) ? $clog2(n_rows) : 1;
  endfunction

  function automatic int cb_f(input int n_cols);
    return (n_cols > 1) ? $clog2(n_cols) : 1;
  endfunction

  // Address is {bank, row, col}.
  function automatic int aw_f(input int n_rows, input int n_cols);
    return 1 + rb_f(n_rows) + cb_f(n_cols);
  endfunction

endpackage

// File: rtl/fb_write_fifo.sv
// Two-entry write FIFO between the SPI pixel writer and the shared RAM port.
module fb_write_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wptr_q, rptr_q;
  logic [1:0]   cnt_q;
  logic         push_ok, pop_ok;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push_ok) wptr_q <= ~wptr_q;
      if (pop_ok)  rptr_q <= ~rptr_q;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/fb_bank_controller.sv
// Double-buffered framebuffer bank controller: scanner reads the front bank, SPI writes fill the back bank.
module fb_bank_controller
  import fb_bank_controller_pkg::*;
#(
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int bitwidth = 8,
  localparam int PW = 3 * bitwidth,
  localparam int RB = rb_f(rows),
  localparam int CB = cb_f(columns),
  localparam int AW = aw_f(rows, columns)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RB-1:0] w_row,
  input  logic [CB-1:0] w_col,
  input  logic [PW-1:0] w_data,
  input  logic          w_en,
  input  logic          w_loaded,
  output logic          w_ready,
  input  logic          r_req,
  input  logic [RB-1:0] r_row,
  input  logic [CB-1:0] r_col,
  output logic          r_valid,
  output logic [PW-1:0] r_data,
  input  logic          frame_start,
  output logic [AW-1:0] m_addr,
  output logic          m_wen,
  output logic [PW-1:0] m_wdata,
  input  logic [PW-1:0] m_rdata,
  output logic          front_bank,
  output logic          swap_pending,
  output logic          err
);

  localparam int FW = PW + RB + CB;

  fb_state_e     state_q, state_d;
  logic          front_q, w_ready_q, r_valid_q, err_q, err_d;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0] fifo_din, fifo_dout;
  logic [RB-1:0] head_row;
  logic [CB-1:0] head_col;
  logic [PW-1:0] head_data;

  assign fifo_push = w_en && (state_q == ST_FILL);
  assign fifo_din  = {w_row, w_col, w_data};
  assign {head_row, head_col, head_data} = fifo_dout;

  fb_write_fifo #(.W(FW)) u_wfifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Reads always win the RAM; queued writes drain into idle cycles.
  always_comb begin
    m_addr   = '0;
    m_wen    = 1'b0;
    m_wdata  = '0;
    fifo_pop = 1'b0;
    if (rst) begin
      if (r_req) begin
        m_addr = {front_q, r_row, r_col};
      end else if (!fifo_empty) begin
        m_addr   = {~front_q, head_row, head_col};
        m_wen    = 1'b1;
        m_wdata  = head_data;
        fifo_pop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_FILL;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL:    if (w_loaded) state_d = ST_DRAIN;
      ST_DRAIN:   if (fifo_empty && !fifo_pop) state_d = ST_PENDING;
      ST_PENDING: if (frame_start) state_d = ST_SWAP;
      ST_SWAP:    state_d = ST_FILL;
      default:    state_d = ST_FILL;
    endcase
  end

  always_comb begin
    swap_pending = (state_q == ST_DRAIN) || (state_q == ST_PENDING);
  end

  // Dropped beats: outside FILL, or into a full FIFO.
  assign err_d = err_q || (w_en && ((state_q != ST_FILL) || fifo_full));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front_q   <= 1'b0;
      w_ready_q <= 1'b0;
      r_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == ST_SWAP) front_q <= ~front_q;
      w_ready_q <= (state_d == ST_FILL);
      r_valid_q <= r_req;
      err_q     <= err_d;
    end
  end

  assign w_ready    = w_ready_q;
  assign r_valid    = r_valid_q;
  assign r_data     = m_rdata;
  assign front_bank = front_q;
  assign err        = err_q;

endmodule

// File: tb/tb_fb_bank_controller.sv
// Directed self-checking bench for fb_bank_controller with a 1-cycle-latency RAM model.
module tb_fb_bank_controller;

  localparam int RB = 3;
  localparam int CB = 5;
  localparam int PW = 24;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [RB-1:0] w_row, r_row;
  logic [CB-1:0] w_col, r_col;
  logic [PW-1:0] w_data, r_data, m_wdata, m_rdata;
  logic          w_en, w_loaded, w_ready, r_req, r_valid, frame_start;
  logic [AW-1:0] m_addr;
  logic          m_wen, front_bank, swap_pending, err;

  int tests = 0;
  int fails = 0;

  logic [PW-1:0] ram [1 << AW];

  always #5 clk = ~clk;

  fb_bank_controller #(.rows(8), .columns(32), .bitwidth(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .w_row        (w_row),
    .w_col        (w_col),
    .w_data       (w_data),
    .w_en         (w_en),
    .w_loaded     (w_loaded),
    .w_ready      (w_ready),
    .r_req        (r_req),
    .r_row        (r_row),
    .r_col        (r_col),
    .r_valid      (r_valid),
    .r_data       (r_data),
    .frame_start  (frame_start),
    .m_addr       (m_addr),
    .m_wen        (m_wen),
    .m_wdata      (m_wdata),
    .m_rdata      (m_rdata),
    .front_bank   (front_bank),
    .swap_pending (swap_pending),
    .err          (err)
  );

  // Single-port RAM, 1-cycle read; one location preloaded with a known pixel.
  always @(posedge clk) begin
    if (m_wen) ram[m_addr] <= m_wdata;
    m_rdata <= (m_addr == 9'h1C9) ? 24'h00ed1f : ram[m_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [RB-1:0] r, input logic [CB-1:0] c, input logic [PW-1:0] d);
    w_en = 1'b1; w_row = r; w_col = c; w_data = d;
  endtask

  initial begin
    rst = 1'b0; w_en = 1'b0; w_loaded = 1'b0; frame_start = 1'b0;
    w_row = '0; w_col = '0; w_data = '0;
    r_req = 1'b1; r_row = 3'd7; r_col = 5'd31;
    tick(); tick(); #1;
    check("rst_w_ready", w_ready, 0);
    check("rst_m_wen", m_wen, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_front", front_bank, 0);
    check("rst_swap_pending", swap_pending, 0);
    check("rst_err", err, 0);
    check("rst_r_valid", r_valid, 0);

    rst = 1'b1; r_req = 1'b0;
    tick();
    check("post_rst_w_ready", w_ready, 1);
    check("post_rst_front", front_bank, 0);
    check("post_rst_err", err, 0);

    // Single write into back bank 1
    wr(3'd3, 5'd5, 24'hffff07);
    tick(); w_en = 1'b0; #1;
    check("wr_m_wen", m_wen, 1);
    check("wr_m_addr", m_addr, 9'h165);
    check("wr_m_wdata", m_wdata, 24'hffff07);
    tick(); #1;
    check("wr_done_m_wen", m_wen, 0);

    // Contention: reads hold the RAM for 3 cycles while 2 writes queue
    r_req = 1'b1; r_row = 3'd2; r_col = 5'd3;
    wr(3'd1, 5'd1, 24'h111111); #1;
    check("cont_c0_m_wen", m_wen, 0);
    tick(); wr(3'd2, 5'd2, 24'h222222); #1;
    check("cont_c1_m_wen", m_wen, 0);
    check("cont_c1_m_addr", m_addr, 9'h043);
    tick(); w_en = 1'b0; #1;
    check("cont_c2_m_wen", m_wen, 0);
    tick(); r_req = 1'b0; #1;
    check("cont_w1_m_wen", m_wen, 1);
    check("cont_w1_m_addr", m_addr, 9'h121);
    check("cont_w1_m_wdata", m_wdata, 24'h111111);
    tick(); #1;
    check("cont_w2_m_wen", m_wen, 1);
    check("cont_w2_m_addr", m_addr, 9'h142);
    check("cont_w2_m_wdata", m_wdata, 24'h222222);
    tick(); #1;
    check("cont_idle_m_wen", m_wen, 0);
    check("cont_err", err, 0);

    // Overflow: third push into a full FIFO is dropped
    r_req = 1'b1;
    wr(3'd4, 5'd6, 24'h333333);
    tick(); wr(3'd5, 5'd7, 24'h444444);
    tick(); wr(3'd6, 5'd8, 24'h555555); #1;
    check("ovf_err_before", err, 0);
    tick(); w_en = 1'b0; #1;
    check("ovf_err", err, 1);
    check("ovf_m_wen", m_wen, 0);
    tick(); r_req = 1'b0; #1;
    check("ovf_w3_m_addr", m_addr, 9'h186);
    check("ovf_w3_m_wen", m_wen, 1);
    tick(); #1;
    check("ovf_w4_m_addr", m_addr, 9'h1a7);
    check("ovf_w4_m_wdata", m_wdata, 24'h444444);
    tick(); #1;
    check("ovf_w5_dropped", m_wen, 0);

    // Swap: w_loaded, frame_start 10 cycles later
    w_loaded = 1'b1; #1;
    check("swap_d0_pending", swap_pending, 0);
    check("swap_d0_w_ready", w_ready, 1);
    tick(); w_loaded = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      #1;
      check("swap_wait_pending", swap_pending, 1);
      check("swap_wait_w_ready", w_ready, 0);
      tick();
    end
    frame_start = 1'b1; #1;
    check("swap_d10_pending", swap_pending, 1);
    tick(); frame_start = 1'b0;
    r_req = 1'b1; r_row = 3'd1; r_col = 5'd2; #1;
    check("swap_cycle_pending", swap_pending, 0);
    check("swap_cycle_front", front_bank, 0);
    check("swap_cycle_w_ready", w_ready, 0);
    check("swap_cycle_rd_addr", m_addr, 9'h022);
    tick(); r_req = 1'b0; frame_start = 1'b1; #1;
    check("swap_after_front", front_bank, 1);
    check("swap_after_w_ready", w_ready, 1);
    check("swap_after_r_valid", r_valid, 1);
    tick(); frame_start = 1'b0;

    // Read from the new front bank
    r_req = 1'b1; r_row = 3'd6; r_col = 5'd9; #1;
    check("rd_front_kept", front_bank, 1);
    check("rd_m_addr", m_addr, 9'h1C9);
    check("rd_m_wen", m_wen, 0);
    tick(); r_req = 1'b0; #1;
    check("rd_r_valid", r_valid, 1);
    check("rd_r_data", r_data, 24'h00ed1f);
    tick(); #1;
    check("rd_r_valid_drop", r_valid, 0);

    // Reset mid-drain discards queued write and pending swap
    r_req = 1'b1; wr(3'd0, 5'd1, 24'h666666); w_loaded = 1'b1;
    tick(); w_en = 1'b0; w_loaded = 1'b0; #1;
    check("mid_drain_pending", swap_pending, 1);
    check("mid_drain_m_wen", m_wen, 0);
    tick(); rst = 1'b0; #1;
    check("mid_rst_pending", swap_pending, 0);
    check("mid_rst_front", front_bank, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_w_ready", w_ready, 0);
    check("mid_rst_m_wen", m_wen, 0);
    tick(); rst = 1'b1; r_req = 1'b0;
    tick(); #1;
    check("mid_rel_w_ready", w_ready, 1);
    check("mid_rel_fifo_empty", m_wen, 0);
    check("mid_rel_pending", swap_pending, 0);

    // Write outside FILL is dropped and flagged
    w_loaded = 1'b1;
    tick(); w_loaded = 1'b0; wr(3'd2, 5'd4, 24'h777777); #1;
    check("nofill_err_before", err, 0);
    tick(); w_en = 1'b0; #1;
    check("nofill_err", err, 1);
    check("nofill_pending", swap_pending, 1);
    check("nofill_m_wen", m_wen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
